// File: rtl/ascii_ram_writer.sv
// ascii_ram_writer: write-side producer for the POV column RAM.
// Accepts ASCII characters on a valid/ready handshake, expands each one
// through a built-in 5x7 column font and writes COLS_PER_CHAR consecutive
// column bytes (glyph plus one blank spacer) at the current character slot.
// A clear request blanks every RAM column. leer_ram hands the RAM address
// port to the column scanner whenever no write is in progress.
// Optional feature macro: ASCII_WR_BLANK_EN adds a 'blank' input and a HOLD
// state so that writes and clears only start while the rotor is in the
// non-displayed arc.
module ascii_ram_writer #(
    parameter int RAM_DEPTH     = 256,
    parameter int GLYPH_W       = 5,
    parameter int COLS_PER_CHAR = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear,
`ifdef ASCII_WR_BLANK_EN
    input  logic       blank,
`endif
    output logic [7:0] dir_ram,
    output logic [7:0] data_ram,
    output logic       we_ram,
    output logic       leer_ram,
    output logic       busy
);

    localparam int MAX_CHARS = RAM_DEPTH / COLS_PER_CHAR;
    localparam int CUR_W     = $clog2(MAX_CHARS);

    localparam logic [7:0]       LAST_ADDR = 8'(RAM_DEPTH - 1);
    localparam logic [2:0]       LAST_COL  = 3'(COLS_PER_CHAR - 1);
    localparam logic [CUR_W-1:0] LAST_CUR  = CUR_W'(MAX_CHARS - 1);
    localparam logic [7:0]       CODE_CR   = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
`ifdef ASCII_WR_BLANK_EN
        , S_HOLD = 2'd3
`endif
    } state_t;

    // 5x7 column font; column 0 in the top byte, bit0 = top LED row.
    // Lowercase folds to uppercase; anything unmapped shows a hollow box.
    function automatic logic [39:0] font_glyph(input logic [7:0] code);
        logic [7:0] c;
        c = (code >= 8'h61 && code <= 8'h7A) ? code - 8'h20 : code;
        case (c)
            8'h20: font_glyph = 40'h00_00_00_00_00;
            8'h21: font_glyph = 40'h00_00_5F_00_00;
            8'h22: font_glyph = 40'h00_07_00_07_00;
            8'h23: font_glyph = 40'h14_7F_14_7F_14;
            8'h24: font_glyph = 40'h24_2A_7F_2A_12;
            8'h25: font_glyph = 40'h23_13_08_64_62;
            8'h26: font_glyph = 40'h36_49_55_22_50;
            8'h27: font_glyph = 40'h00_05_03_00_00;
            8'h28: font_glyph = 40'h00_1C_22_41_00;
            8'h29: font_glyph = 40'h00_41_22_1C_00;
            8'h2A: font_glyph = 40'h08_2A_1C_2A_08;
            8'h2B: font_glyph = 40'h08_08_3E_08_08;
            8'h2C: font_glyph = 40'h00_50_30_00_00;
            8'h2D: font_glyph = 40'h08_08_08_08_08;
            8'h2E: font_glyph = 40'h00_60_60_00_00;
            8'h2F: font_glyph = 40'h20_10_08_04_02;
            8'h30: font_glyph = 40'h3E_51_49_45_3E;
            8'h31: font_glyph = 40'h00_42_7F_40_00;
            8'h32: font_glyph = 40'h42_61_51_49_46;
            8'h33: font_glyph = 40'h21_41_45_4B_31;
            8'h34: font_glyph = 40'h18_14_12_7F_10;
            8'h35: font_glyph = 40'h27_45_45_45_39;
            8'h36: font_glyph = 40'h3C_4A_49_49_30;
            8'h37: font_glyph = 40'h01_71_09_05_03;
            8'h38: font_glyph = 40'h36_49_49_49_36;
            8'h39: font_glyph = 40'h06_49_49_29_1E;
            8'h3A: font_glyph = 40'h00_36_36_00_00;
            8'h3B: font_glyph = 40'h00_56_36_00_00;
            8'h3C: font_glyph = 40'h08_14_22_41_00;
            8'h3D: font_glyph = 40'h14_14_14_14_14;
            8'h3E: font_glyph = 40'h00_41_22_14_08;
            8'h3F: font_glyph = 40'h02_01_51_09_06;
            8'h40: font_glyph = 40'h32_49_79_41_3E;
            8'h41: font_glyph = 40'h7E_11_11_11_7E;
            8'h42: font_glyph = 40'h7F_49_49_49_36;
            8'h43: font_glyph = 40'h3E_41_41_41_22;
            8'h44: font_glyph = 40'h7F_41_41_22_1C;
            8'h45: font_glyph = 40'h7F_49_49_49_41;
            8'h46: font_glyph = 40'h7F_09_09_01_01;
            8'h47: font_glyph = 40'h3E_41_41_51_32;
            8'h48: font_glyph = 40'h7F_08_08_08_7F;
            8'h49: font_glyph = 40'h00_41_7F_41_00;
            8'h4A: font_glyph = 40'h20_40_41_3F_01;
            8'h4B: font_glyph = 40'h7F_08_14_22_41;
            8'h4C: font_glyph = 40'h7F_40_40_40_40;
            8'h4D: font_glyph = 40'h7F_02_04_02_7F;
            8'h4E: font_glyph = 40'h7F_04_08_10_7F;
            8'h4F: font_glyph = 40'h3E_41_41_41_3E;
            8'h50: font_glyph = 40'h7F_09_09_09_06;
            8'h51: font_glyph = 40'h3E_41_51_21_5E;
            8'h52: font_glyph = 40'h7F_09_19_29_46;
            8'h53: font_glyph = 40'h46_49_49_49_31;
            8'h54: font_glyph = 40'h01_01_7F_01_01;
            8'h55: font_glyph = 40'h3F_40_40_40_3F;
            8'h56: font_glyph = 40'h1F_20_40_20_1F;
            8'h57: font_glyph = 40'h7F_20_18_20_7F;
            8'h58: font_glyph = 40'h63_14_08_14_63;
            8'h59: font_glyph = 40'h03_04_78_04_03;
            8'h5A: font_glyph = 40'h61_51_49_45_43;
            default: font_glyph = 40'h7F_41_41_41_7F;
        endcase
    endfunction

    // One column byte of a character; columns past the glyph are the spacer.
    function automatic logic [7:0] glyph_col(input logic [7:0] code, input logic [2:0] idx);
        logic [39:0] g;
        g = font_glyph(code);
        if (idx >= 3'(GLYPH_W)) begin
            glyph_col = 8'h00;
        end else begin
            case (idx)
                3'd0:    glyph_col = g[39:32];
                3'd1:    glyph_col = g[31:24];
                3'd2:    glyph_col = g[23:16];
                3'd3:    glyph_col = g[15:8];
                default: glyph_col = g[7:0];
            endcase
        end
    endfunction

    state_t           state, state_n;
    logic [2:0]       col, col_n;
    logic [7:0]       code_q, code_n;
    logic [CUR_W-1:0] cursor, cursor_n;
    logic [7:0]       clr_addr, clr_addr_n;
    logic             clr_pend, clr_pend_n;
    logic [7:0]       dir_n, data_n;
    logic             we_n, leer_n, busy_n;
    logic             rdy_q, rdy_n;
    logic             start_write, start_clear;
    logic             blank_ok;
    logic [7:0]       base;

`ifdef ASCII_WR_BLANK_EN
    assign blank_ok = blank;
`else
    assign blank_ok = 1'b1;
`endif

    // First RAM column of the current character slot.
    assign base = 8'(cursor) * 8'(COLS_PER_CHAR);

    // A clear request on the same cycle wins over a character, so ready
    // drops immediately rather than one cycle later.
    assign char_ready = rdy_q & ~clear & ~rst;

    // Next-state and next-output logic for the write/clear sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned and no latch is inferred.
        state_n     = state;
        col_n       = col;
        code_n      = code_q;
        cursor_n    = cursor;
        clr_addr_n  = clr_addr;
        clr_pend_n  = clr_pend;
        dir_n       = dir_ram;
        data_n      = data_ram;
        we_n        = 1'b0;
        start_write = 1'b0;
        start_clear = 1'b0;

        case (state)
            S_IDLE: begin
                if (clear || clr_pend) begin
                    if (blank_ok) start_clear = 1'b1;
                    else          clr_pend_n  = 1'b1;
                end else if (char_valid && rdy_q) begin
                    if (char_in == CODE_CR) begin
                        cursor_n = '0;
                    end else begin
                        code_n = char_in;
                        if (blank_ok) begin
                            start_write = 1'b1;
                        end else begin
`ifdef ASCII_WR_BLANK_EN
                            state_n = S_HOLD;
`endif
                        end
                    end
                end
            end
`ifdef ASCII_WR_BLANK_EN
            S_HOLD: begin
                if (clear) clr_pend_n = 1'b1;
                if (blank_ok) start_write = 1'b1;
            end
`endif
            S_WRITE: begin
                if (clear) clr_pend_n = 1'b1;
                if (col == LAST_COL) begin
                    state_n  = S_IDLE;
                    cursor_n = (cursor == LAST_CUR) ? '0 : cursor + 1'b1;
                end else begin
                    col_n  = col + 3'd1;
                    we_n   = 1'b1;
                    dir_n  = dir_ram + 8'd1;
                    data_n = glyph_col(code_q, col + 3'd1);
                end
            end
            S_CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_n    = S_IDLE;
                    cursor_n   = '0;
                    clr_pend_n = 1'b0;
                end else begin
                    clr_addr_n = clr_addr + 8'd1;
                    we_n       = 1'b1;
                    dir_n      = clr_addr + 8'd1;
                    data_n     = 8'h00;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (start_write) begin
            state_n = S_WRITE;
            col_n   = 3'd0;
            we_n    = 1'b1;
            dir_n   = base;
            data_n  = glyph_col(code_n, 3'd0);
        end

        if (start_clear) begin
            state_n    = S_CLEAR;
            clr_addr_n = 8'd0;
            we_n       = 1'b1;
            dir_n      = 8'd0;
            data_n     = 8'h00;
        end

        leer_n = ~we_n;
        busy_n = (state_n == S_WRITE) || (state_n == S_CLEAR);
        rdy_n  = (state_n == S_IDLE) && !clr_pend_n;
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: reset restores only control state; the column RAM is outside
        // this block and keeps whatever was last written to it.
        if (rst) begin
            state    <= S_IDLE;
            col      <= 3'd0;
            code_q   <= 8'h00;
            cursor   <= '0;
            clr_addr <= 8'd0;
            clr_pend <= 1'b0;
            dir_ram  <= 8'd0;
            data_ram <= 8'h00;
            we_ram   <= 1'b0;
            leer_ram <= 1'b1;
            busy     <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state    <= state_n;
            col      <= col_n;
            code_q   <= code_n;
            cursor   <= cursor_n;
            clr_addr <= clr_addr_n;
            clr_pend <= clr_pend_n;
            dir_ram  <= dir_n;
            data_ram <= data_n;
            we_ram   <= we_n;
            leer_ram <= leer_n;
            busy     <= busy_n;
            rdy_q    <= rdy_n;
        end
    end

endmodule

// File: tb/tb_ascii_ram_writer.sv
// tb_ascii_ram_writer: directed stimulus for ascii_ram_writer with a
// scoreboard of expected RAM writes; a negedge monitor pops and compares
// each write the DUT presents.
module tb_ascii_ram_writer;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       clear;
    logic [7:0] dir_ram;
    logic [7:0] data_ram;
    logic       we_ram;
    logic       leer_ram;
    logic       busy;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_pass  = 0;
    int  n_total = 0;
    int  tb_cursor = 0;

    always #5 clk = ~clk;

    ascii_ram_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear      (clear),
        .dir_ram    (dir_ram),
        .data_ram   (data_ram),
        .we_ram     (we_ram),
        .leer_ram   (leer_ram),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Hand-entered glyphs for the characters this bench sends.
    function automatic logic [7:0] exp_col(input logic [7:0] code, input int i);
        logic [7:0] g [5];
        case (code)
            8'h41, 8'h61: g = '{8'h7E, 8'h11, 8'h11, 8'h11, 8'h7E};
            8'h30:        g = '{8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E};
            8'h49:        g = '{8'h00, 8'h41, 8'h7F, 8'h41, 8'h00};
            default:      g = '{8'h7F, 8'h41, 8'h41, 8'h41, 8'h7F};
        endcase
        if (i < 5) return g[i];
        return 8'h00;
    endfunction

    task automatic push_char(input logic [7:0] code);
        for (int i = 0; i < 6; i++) begin
            wr_t e;
            e.addr = 8'(tb_cursor * 6 + i);
            e.data = exp_col(code, i);
            exp_q.push_back(e);
        end
        tb_cursor = (tb_cursor == 41) ? 0 : tb_cursor + 1;
    endtask

    task automatic push_clear();
        for (int i = 0; i < 256; i++) begin
            wr_t e;
            e.addr = 8'(i);
            e.data = 8'h00;
            exp_q.push_back(e);
        end
        tb_cursor = 0;
    endtask

    // Returns at a negedge with char_ready high, or records a timeout.
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check("ready_timeout", 32'(char_ready), 32'd1);
    endtask

    task automatic send_char(input logic [7:0] code);
        wait_ready();
        char_in    = code;
        char_valid = 1'b1;
        if (code == 8'h0D) tb_cursor = 0;
        else push_char(code);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        wait_ready();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        tb_cursor = 0;
    endtask

    // Scoreboard monitor: every presented write must match the next expected one.
    always @(negedge clk) begin
        if (!rst && we_ram) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got dir_ram=%0d data_ram=%02h, expected no write",
                         dir_ram, data_ram);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(dir_ram), 32'(mon_e.addr));
                check("wr_data", 32'(data_ram), 32'(mon_e.data));
                check("wr_leer", 32'(leer_ram), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        clear      = 1'b0;

        // Reset: 3 cycles held, ready the cycle after release.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_low", 32'(char_ready), 32'd0);
        check("rst_we", 32'(we_ram), 32'd0);
        @(negedge clk);
        check("rst_ready_high", 32'(char_ready), 32'd1);
        check("rst_leer", 32'(leer_ram), 32'd1);
        check("rst_dir", 32'(dir_ram), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 'A' at slot 0 with cycle-exact handshake timing.
        send_char(8'h41);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("a_we_high", 32'(we_ram), 32'd1);
            check("a_ready_low", 32'(char_ready), 32'd0);
            check("a_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("a_ready_back", 32'(char_ready), 32'd1);
        check("a_we_low", 32'(we_ram), 32'd0);
        check("a_leer_back", 32'(leer_ram), 32'd1);
        check("a_busy_low", 32'(busy), 32'd0);
        check("a_drain", 32'(exp_q.size()), 32'd0);

        // 42 x '0' fills slots 0..41, then 'I' wraps to slot 0.
        do_reset();
        for (int i = 0; i < 42; i++) send_char(8'h30);
        send_char(8'h49);
        drain("wrap_drain");

        // Lowercase fold and box glyph for an unmapped code.
        do_reset();
        send_char(8'h61);
        send_char(8'h7F);
        drain("fold_box_drain");

        // Clear on the 3rd write cycle: character finishes, then full clear.
        do_reset();
        send_char(8'h30);
        @(posedge clk);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        push_clear();
        drain("clear_drain");
        send_char(8'h41);
        drain("after_clear_drain");

        // 'A' at slot 1, CR returns to slot 0 without writing, 'I' at slot 0.
        send_char(8'h41);
        send_char(8'h0D);
        @(negedge clk);
        check("cr_ready", 32'(char_ready), 32'd1);
        check("cr_no_write", 32'(we_ram), 32'd0);
        send_char(8'h49);
        drain("cr_drain");

        // Clear beats a simultaneous character; reset on the 2nd clear cycle.
        wait_ready();
        clear      = 1'b1;
        char_valid = 1'b1;
        char_in    = 8'h49;
        #1;
        check("clear_blocks_ready", 32'(char_ready), 32'd0);
        begin
            wr_t e;
            e.addr = 8'd0;
            e.data = 8'h00;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        clear      = 1'b0;
        char_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_clear_we", 32'(we_ram), 32'd0);
        check("rst_mid_clear_leer", 32'(leer_ram), 32'd1);
        check("rst_mid_clear_busy", 32'(busy), 32'd0);
        check("rst_mid_clear_q", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        tb_cursor = 0;
        send_char(8'h49);
        drain("rst_cursor_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
